// File: rtl/ds_pipe_ctrl_if.sv
// Decode-stage handshake bundle: fetch->decode bus, execute handshake,
// writeback/execute hazard sources, and the counter observation outputs.
interface ds_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             fs_to_ds_valid;
  logic [15:0]      fs_to_ds_bus;
  logic             ds_allowin;
  logic [15:0]      ds_inst;
  logic             ds_to_es_valid;
  logic             es_allowin;
  logic             es_we;
  logic [1:0]       es_dest;
  logic             ws_we;
  logic [1:0]       ws_dest;
  logic             flush;
  logic             cnt_clr;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] issue_cnt;

  modport master (
    output fs_to_ds_valid, fs_to_ds_bus, es_allowin, es_we, es_dest,
           ws_we, ws_dest, flush, cnt_clr,
    input  ds_allowin, ds_inst, ds_to_es_valid, stall_cnt, issue_cnt
  );

  modport slave (
    input  fs_to_ds_valid, fs_to_ds_bus, es_allowin, es_we, es_dest,
           ws_we, ws_dest, flush, cnt_clr,
    output ds_allowin, ds_inst, ds_to_es_valid, stall_cnt, issue_cnt
  );
endinterface

// File: rtl/ds_pipe_ctrl.sv
// Decode-stage pipeline control: one-entry instruction register with
// RAW hazard stall against execute/writeback, flush, and stall/issue counters.
module ds_pipe_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           resetn,
  ds_pipe_ctrl_if.slave pipe
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } occ_t;

  occ_t             occ;
  logic [15:0]      inst_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] issue_q;

  logic       ds_valid;
  logic [3:0] op;
  logic [1:0] rx;
  logic [1:0] ry;
  logic       op_live;
  logic       es_hit;
  logic       ws_hit;
  logic       hazard;
  logic       ready_go;
  logic       allowin;
  logic       to_es_valid;
  logic       stall_inc;
  logic       issue_inc;

  // HOLD vs ISSUE is decided combinationally from the occupied register.
  always_comb begin
    ds_valid    = (occ == FULL);
    op          = inst_q[7:4];
    ry          = inst_q[3:2];
    rx          = inst_q[1:0];
    op_live     = op inside {4'd1, 4'd2, 4'd3, 4'd4};
    es_hit      = pipe.es_we & ((pipe.es_dest == rx) | (pipe.es_dest == ry));
    ws_hit      = pipe.ws_we & ((pipe.ws_dest == rx) | (pipe.ws_dest == ry));
    hazard      = ds_valid & op_live & (es_hit | ws_hit);
    ready_go    = ~hazard;
    allowin     = ~ds_valid | (ready_go & pipe.es_allowin);
    to_es_valid = ds_valid & ready_go & ~pipe.flush;
    stall_inc   = hazard & ~pipe.flush;
    issue_inc   = to_es_valid & pipe.es_allowin;
  end

  assign pipe.ds_allowin     = allowin;
  assign pipe.ds_inst        = inst_q;
  assign pipe.ds_to_es_valid = to_es_valid;
  assign pipe.stall_cnt      = stall_q;
  assign pipe.issue_cnt      = issue_q;

  // Flush wins over a same-edge refill, so an arriving instruction is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ    <= EMPTY;
      inst_q <= '0;
    end else if (pipe.flush) begin
      occ <= EMPTY;
    end else if (allowin) begin
      occ <= pipe.fs_to_ds_valid ? FULL : EMPTY;
      if (pipe.fs_to_ds_valid) begin
        inst_q <= pipe.fs_to_ds_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
      issue_q <= '0;
    end else if (pipe.cnt_clr) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (issue_inc) begin
        issue_q <= issue_q + 1'b1;
      end
    end
  end
endmodule

// File: doc/ds_pipe_ctrl.md
DS_PIPE_CTRL -- requirements
Module: ds_pipe_ctrl

Interface
REQ-001 CNT_W, default 8: width of the stall and issue counters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  one clock; reset is asynchronous and active-low.
REQ-004 fs_to_ds_valid  input  1  fetch stage presents a valid instruction.
REQ-005 fs_to_ds_bus  input  16  instruction bus: PC[15:8], OP[7:4], RY[3:2], RX[1:0].
REQ-006 ds_allowin  output  1  decode stage accepts fs_to_ds_bus this cycle.
REQ-007 ds_inst  output  16  registered instruction held in decode, feeds the decoder.
REQ-008 ds_to_es_valid  output  1  decoded instruction handed to execute this cycle.
REQ-009 es_allowin  input  1  execute stage accepts an instruction this cycle.
REQ-010 es_we, es_dest  input  1, 2  execute-stage register write enable and destination.
REQ-011 ws_we, ws_dest  input  1, 2  writeback-stage register write enable and destination.
REQ-012 flush  input  1  discard the instruction held in decode.
REQ-013 cnt_clr  input  1  synchronous clear of both counters.
REQ-014 stall_cnt  output  CNT_W  cycles spent stalled on a hazard, saturating.
REQ-015 issue_cnt  output  CNT_W  instructions handed to execute, wrapping.

Function
REQ-016 Internal state: ds_valid (1 bit), ds_inst register, two counters; no other storage.
REQ-017 States: EMPTY (ds_valid=0), HOLD (ds_valid=1, not issuing this cycle), ISSUE (ds_valid=1, ds_ready_go=1, es_allowin=1).
REQ-018 op_live = ds_inst[7:4] in {0001,0010,0011,0100}; other OP codes are NOPs that read no registers.
REQ-019 hazard = ds_valid & op_live & ((es_we & (es_dest==RX | es_dest==RY)) | (ws_we & (ws_dest==RX | ws_dest==RY))), using ds_inst RX/RY.
REQ-020 ds_ready_go = ~hazard; NOPs never stall.
REQ-021 ds_allowin = ~ds_valid | (ds_ready_go & es_allowin), combinational, independent of fs_to_ds_valid.
REQ-022 ds_to_es_valid = ds_valid & ds_ready_go & ~flush, combinational.
REQ-023 On an edge with ds_allowin=1: ds_valid <= fs_to_ds_valid; ds_inst <= fs_to_ds_bus only if fs_to_ds_valid=1, otherwise ds_inst holds.
REQ-024 On an edge with ds_allowin=0: ds_valid and ds_inst hold.
REQ-025 flush=1 forces ds_valid <= 0 at the next edge, overriding REQ-023/024, and suppresses issue in the same cycle; an instruction arriving with flush=1 is dropped.
REQ-026 Latency: instruction accepted at edge N appears on ds_inst after edge N and can issue in cycle N+1 at the earliest; back-to-back throughput 1 instruction per cycle without hazards.
REQ-027 Transitions: EMPTY->HOLD/ISSUE on accept; ISSUE->EMPTY when no new valid instruction; ISSUE->ISSUE/HOLD on same-edge refill; HOLD->HOLD while hazard or ~es_allowin; any state->EMPTY on flush.
REQ-028 stall_cnt increments by 1 each cycle with ds_valid & hazard & ~flush; it saturates at 2^CNT_W-1.
REQ-029 issue_cnt increments by 1 each cycle ds_to_es_valid & es_allowin; it wraps from 2^CNT_W-1 to 0.
REQ-030 cnt_clr=1 zeroes both counters at the next edge, taking priority over the same-cycle increment.
REQ-031 es_allowin=0 with no hazard does not increment stall_cnt.

Reset
REQ-032 resetn=0 asynchronously sets ds_valid=0, ds_inst=16'h0000, stall_cnt=0, issue_cnt=0; hence ds_allowin=1 and ds_to_es_valid=0 during reset.
REQ-033 Reset asserted mid-stall discards the held instruction; after release, the block is in EMPTY and the next fs_to_ds_valid is accepted.

Verification
REQ-034 Stream bus=16'h0510, 16'h0621, 16'h0732 with es_allowin=1 and no writes -> each issues one cycle after acceptance, issue_cnt=3, stall_cnt=0.
REQ-035 Hold ds_inst=16'h0A16 (RX=2, RY=1) with es_we=1, es_dest=1 for 3 cycles -> ds_to_es_valid=0, ds_allowin=0, stall_cnt=3; issues in the cycle es_we drops.
REQ-036 NOP 16'h0B00 with ws_we=1, ws_dest=0 -> no stall, issues next cycle.
REQ-037 es_allowin=0 for 2 cycles with a valid live op -> instruction holds, stall_cnt unchanged, ds_allowin=0.
REQ-038 flush=1 while holding a stalled instruction and fs_to_ds_valid=1 -> no issue, ds_valid=0 next cycle, new instruction dropped.
REQ-039 CNT_W=8: force 300 hazard cycles, then cnt_clr -> stall_cnt sticks at 255, then reads 0 after the clear edge.
